// File: rtl/weight_stream_loader.sv
// Streams bytes from the flash reader into the LSTM weight and bias buffers.
// Words are assembled little-endian; all weights are written first, then all biases.
module weight_stream_loader #(
    parameter int hidden_size    = 1,
    parameter int ADDR_WIDTHAD   = $clog2(hidden_size*hidden_size*4),
    parameter int ADDR_WIDTHBIAS = $clog2(hidden_size*4)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [7:0]                byte_data,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    output logic                      w_we,
    output logic [ADDR_WIDTHAD-1:0]   w_addr,
    output logic [15:0]               w_data,
    output logic                      b_we,
    output logic [ADDR_WIDTHBIAS-1:0] b_addr,
    output logic [15:0]               b_data,
    output logic                      load_busy,
    output logic                      load_done
);
    localparam int NW = hidden_size*hidden_size*4;
    localparam int NB = hidden_size*4;
    localparam logic [ADDR_WIDTHAD-1:0]   W_LAST = ADDR_WIDTHAD'(NW-1);
    localparam logic [ADDR_WIDTHBIAS-1:0] B_LAST = ADDR_WIDTHBIAS'(NB-1);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, FINISH} state_t;
    state_t state, state_nxt;

    logic                      phase;     // 0: expecting low byte, 1: expecting high byte
    logic [7:0]                low_byte;
    logic [ADDR_WIDTHAD-1:0]   w_idx;
    logic [ADDR_WIDTHBIAS-1:0] b_idx;
    logic                      accept;
    logic                      hi_acc;

    assign accept = byte_valid && byte_ready;
    assign hi_acc = accept && phase;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        load_busy  = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
                if (byte_valid && phase && w_idx == W_LAST) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                byte_ready = 1'b1;
                load_busy  = 1'b1;
                if (byte_valid && phase && b_idx == B_LAST) state_nxt = FINISH;
            end
            FINISH: begin
                load_busy = 1'b1;
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= 1'b0;
            low_byte <= '0;
            w_idx    <= '0;
            b_idx    <= '0;
            w_we     <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            b_we     <= 1'b0;
            b_addr   <= '0;
            b_data   <= '0;
        end else begin
            w_we <= 1'b0;
            b_we <= 1'b0;
            if (state == IDLE && load_start) begin
                phase <= 1'b0;
                w_idx <= '0;
                b_idx <= '0;
            end
            if (accept) begin
                phase <= ~phase;
                if (!phase) low_byte <= byte_data;
            end
            // Address/data registers only move with their strobe, so they hold otherwise
            if (hi_acc && state == LOAD_W) begin
                w_we   <= 1'b1;
                w_addr <= w_idx;
                w_data <= {byte_data, low_byte};
                w_idx  <= w_idx + 1'b1;
            end
            if (hi_acc && state == LOAD_B) begin
                b_we   <= 1'b1;
                b_addr <= b_idx;
                b_data <= {byte_data, low_byte};
                b_idx  <= b_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader at hidden_size=1 (4 weight words, 4 bias words).
module tb_weight_stream_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        w_we;
    logic [1:0]  w_addr;
    logic [15:0] w_data;
    logic        b_we;
    logic [1:0]  b_addr;
    logic [15:0] b_data;
    logic        load_busy;
    logic        load_done;

    int checks   = 0;
    int failures = 0;

    weight_stream_loader #(.hidden_size(1)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .load_busy(load_busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    // write log captured mid-cycle
    logic [1:0]  wa[$];
    logic [15:0] wd[$];
    logic [1:0]  ba[$];
    logic [15:0] bd[$];
    logic        bdone[$];
    int          done_cnt = 0;
    int          overlap  = 0;

    always @(negedge clk) begin
        if (w_we) begin wa.push_back(w_addr); wd.push_back(w_data); end
        if (b_we) begin ba.push_back(b_addr); bd.push_back(b_data); bdone.push_back(load_done); end
        if (load_done) done_cnt++;
        if (w_we && b_we) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); ba.delete(); bd.delete(); bdone.delete();
        done_cnt = 0;
        overlap  = 0;
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            byte_data  = 8'hEE;
            @(negedge clk);
        end
    endtask

    task automatic run_load(input bit gap, input bit spur);
        start_load();
        for (int i = 0; i < 16; i++) begin
            load_start = (spur && i == 3);
            send_byte(8'(i + 1), gap);
            load_start = 1'b0;
        end
        byte_valid = 1'b0;
    endtask

    // Expected: bytes 0x01..0x10 per load, weights then biases, addresses 0..3 each
    task automatic verify(input string tag, input int reps);
        logic [15:0] ew, eb;
        chk({tag, "_wcnt"}, wa.size(), reps * 4);
        chk({tag, "_bcnt"}, ba.size(), reps * 4);
        for (int k = 0; k < wa.size() && k < reps * 4; k++) begin
            ew = {8'(2*(k%4) + 2), 8'(2*(k%4) + 1)};
            chk($sformatf("%s_waddr%0d", tag, k), wa[k], k % 4);
            chk($sformatf("%s_wdata%0d", tag, k), wd[k], ew);
        end
        for (int k = 0; k < ba.size() && k < reps * 4; k++) begin
            eb = {8'(2*(k%4) + 10), 8'(2*(k%4) + 9)};
            chk($sformatf("%s_baddr%0d", tag, k), ba[k], k % 4);
            chk($sformatf("%s_bdata%0d", tag, k), bd[k], eb);
            chk($sformatf("%s_bdone%0d", tag, k), bdone[k], (k % 4) == 3);
        end
        chk({tag, "_done_cnt"}, done_cnt, reps);
        chk({tag, "_overlap"}, overlap, 0);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        @(posedge clk); #1;
        chk("reset_outs", {byte_ready, w_we, b_we, load_busy, load_done, w_addr, w_data, b_addr, b_data}, 0);
        // rst beats load_start and byte_valid
        @(negedge clk);
        load_start = 1'b1; byte_valid = 1'b1; byte_data = 8'h55;
        @(posedge clk); #1;
        chk("reset_prio_busy", load_busy, 0);
        chk("reset_prio_ready", byte_ready, 0);
        @(negedge clk);
        rst = 1'b0; load_start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", load_busy, 0);
        chk("idle_ready", byte_ready, 0);

        // contiguous
        clear_log();
        run_load(1'b0, 1'b0);
        @(negedge clk);
        chk("idle_after_load", load_busy, 0);
        verify("contig", 1);

        // gapped
        clear_log();
        run_load(1'b1, 1'b0);
        @(negedge clk);
        verify("gapped", 1);

        // spurious load_start during LOAD_W
        clear_log();
        run_load(1'b0, 1'b1);
        @(negedge clk);
        verify("spur", 1);

        // reset after 5 bytes
        clear_log();
        start_load();
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b0);
        chk("mid_busy", load_busy, 1);
        chk("mid_ready", byte_ready, 1);
        chk("mid_wcnt", wa.size(), 2);
        rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h06;
        @(posedge clk); #1;
        chk("midrst_outs", {byte_ready, w_we, b_we, load_busy, load_done, w_addr, w_data, b_addr, b_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        // 0xFF offered in IDLE, kept up through the load_start cycle
        byte_data = 8'hFF; byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_nowrites", wa.size() + ba.size() + done_cnt, 0);
        run_load(1'b0, 1'b0);
        @(negedge clk);
        verify("after_rst", 1);

        // back-to-back loads, second start on the cycle after load_done
        clear_log();
        run_load(1'b0, 1'b0);
        run_load(1'b0, 1'b0);
        @(negedge clk);
        verify("b2b", 2);

        // hold of address/data when idle
        chk("hold_waddr", w_addr, 3);
        chk("hold_wdata", w_data, 16'h0807);
        chk("hold_bdata", b_data, 16'h100F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/weight_stream_loader.md
WEIGHT_STREAM_LOADER -- requirements
Module: weight_stream_loader

Interface
REQ-001 The block SHALL have parameter hidden_size, default 1, giving the LSTM hidden feature count.
REQ-002 The block SHALL have parameter ADDR_WIDTHAD, default $clog2(hidden_size*hidden_size*4), giving the weight address width.
REQ-003 The block SHALL have parameter ADDR_WIDTHBIAS, default $clog2(hidden_size*4), giving the bias address width.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_start  input  1  one-cycle request to begin a load.
REQ-007 byte_data  input  8  byte from the upstream flash reader.
REQ-008 byte_valid  input  1  byte_data is valid.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 w_we  output  1  weight-buffer write strobe.
REQ-011 w_addr  output  ADDR_WIDTHAD  weight write address.
REQ-012 w_data  output  16  weight write word.
REQ-013 b_we  output  1  bias-buffer write strobe.
REQ-014 b_addr  output  ADDR_WIDTHBIAS  bias write address.
REQ-015 b_data  output  16  bias write word.
REQ-016 load_busy  output  1  a load is in progress.
REQ-017 load_done  output  1  one-cycle pulse at load completion.

Function
REQ-018 Definitions: NW = hidden_size*hidden_size*4 weight words; NB = hidden_size*4 bias words.
REQ-019 FSM states SHALL be IDLE, LOAD_W, LOAD_B and FINISH.
REQ-020 IDLE -> LOAD_W SHALL occur on load_start; word counters and byte phase clear on that edge.
REQ-021 load_start SHALL be ignored in every state other than IDLE.
REQ-022 byte_ready SHALL be 1 exactly in LOAD_W and LOAD_B, and 0 in IDLE and FINISH.
REQ-023 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1; bytes offered while byte_ready=0 SHALL be dropped with no effect.
REQ-024 Words SHALL be little-endian: the first accepted byte is bits [7:0], the second is bits [15:8].
REQ-025 The byte phase SHALL toggle on each accept and be unaffected by byte_valid gaps of any length.
REQ-026 Weight write timing:
- On the accept of a high byte in LOAD_W, the cycle after SHALL show w_we=1 for exactly one cycle.
- In that cycle, w_data = {high, low} and w_addr = the current weight index (0 .. NW-1).
- The weight index increments after each write.
REQ-027 Weight-to-bias transition:
- LOAD_W -> LOAD_B SHALL occur on the edge accepting the high byte of word NW-1.
- byte_ready stays 1, so a byte can be accepted on the very next cycle.
REQ-028 Bias writes SHALL follow the same rules as REQ-026 on b_we, b_addr and b_data, with bias index 0 .. NB-1.
REQ-029 LOAD_B -> FINISH SHALL occur on the edge accepting the high byte of bias word NB-1.
REQ-030 In FINISH, which lasts exactly one cycle:
- The final b_we pulse and load_done=1 coincide.
- The state then returns to IDLE.
REQ-031 w_we and b_we SHALL never be 1 in the same cycle.
- Total writes per load: exactly NW + NB.
- No address is written twice and no address wraps.
REQ-032 load_busy SHALL be 1 in LOAD_W, LOAD_B and FINISH, and 0 in IDLE.
REQ-033 w_addr, w_data, b_addr and b_data SHALL hold their last values when their write strobe is 0.

Reset
REQ-034 On rst=1, at the next edge:
- The state SHALL go to IDLE.
- Counters and byte phase clear.
- All outputs SHALL be 0: byte_ready, w_we, b_we, load_busy, load_done, w_addr, w_data, b_addr, b_data.
REQ-035 rst SHALL take priority over load_start and byte_valid.
REQ-036 A reset mid-load SHALL abandon the load with no further write strobes and no load_done.
REQ-037 A load_start after a mid-load reset SHALL restart from weight index 0 with low-byte phase.

Verification (hidden_size=1: NW=4, NB=4)
REQ-038 Contiguous load: load_start, then bytes 0x01..0x10 with byte_valid held at 1 ->
- Weight writes: w_addr 0..3 with w_data 0x0201, 0x0403, 0x0605, 0x0807.
- Bias writes: b_addr 0..3 with b_data 0x0A09, 0x0C0B, 0x0E0D, 0x100F.
- load_done is 1 on the cycle of the last b_we.
REQ-039 Gapped stream: same bytes with byte_valid low on alternate cycles -> identical writes and data; only timing stretches.
REQ-040 load_start pulsed during LOAD_W -> no restart; counts and addresses unaffected.
REQ-041 rst asserted after 5 bytes -> all outputs 0 next cycle and no further writes; a subsequent full load matches REQ-038.
REQ-042 byte_valid=1 with 0xFF while IDLE, then a load -> 0xFF is never accepted or written.
REQ-043 load_start on the cycle after load_done -> a second complete load with addresses restarting at 0.
